// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of the single mem_bus request port.
// Data has priority; fetch is forced through after STARVE_LIMIT back-to-back data grants; a watchdog aborts hung transfers.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_W       = 18,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [2:0]        d_nbytes,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              err,
   output logic              bus_start_request,
   output logic [ADDR_W-1:0] bus_target_address,
   output logic [2:0]        bus_num_bytes,
   output logic              bus_is_write,
   output logic [31:0]       bus_write_value,
   input  logic              bus_request_done,
   input  logic [31:0]       bus_fetched_value
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;   // 1 = data port owns the bus
   logic              start_q, start_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        nb_q, nb_d;
   logic              we_q, we_d;
   logic [31:0]       wv_q, wv_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              err_q, err_d;
   logic [31:0]       if_rd_q, if_rd_d;
   logic [31:0]       d_rd_q, d_rd_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [TW-1:0]     timer_q, timer_d;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      start_d  = start_q;
      addr_d   = addr_q;
      nb_d     = nb_q;
      we_d     = we_q;
      wv_d     = wv_q;
      if_ack_d = 1'b0;
      d_ack_d  = 1'b0;
      err_d    = 1'b0;
      if_rd_d  = if_rd_q;
      d_rd_d   = d_rd_q;
      starve_d = starve_q;
      timer_d  = timer_q;

      case (state_q)
         IDLE: begin
            if (if_req && (!d_req || starve_q == SW'(STARVE_LIMIT))) begin
               owner_d  = 1'b0;
               addr_d   = if_addr;
               nb_d     = 3'd4;
               we_d     = 1'b0;
               wv_d     = '0;
               start_d  = 1'b1;
               starve_d = '0;
               state_d  = BUSY;
            end else if (d_req) begin
               owner_d  = 1'b1;
               addr_d   = d_addr;
               nb_d     = d_nbytes;
               we_d     = d_we;
               wv_d     = d_wdata;
               start_d  = 1'b1;
               // fetch would have won at the limit, so this increment never exceeds it
               starve_d = if_req ? starve_q + SW'(1) : '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            timer_d = timer_q + TW'(1);
            if (bus_request_done) begin
               start_d = 1'b0;
               state_d = RELEASE;
               if (owner_q) begin
                  d_ack_d = 1'b1;
                  if (!we_q) d_rd_d = bus_fetched_value;
               end else begin
                  if_ack_d = 1'b1;
                  if_rd_d  = bus_fetched_value;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               start_d  = 1'b0;
               state_d  = RELEASE;
               err_d    = 1'b1;
               if_ack_d = ~owner_q;
               d_ack_d  = owner_q;
            end
         end
         RELEASE: begin
            start_d = 1'b0;
            timer_d = '0;
            if (!bus_request_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         start_q  <= 1'b0;
         addr_q   <= '0;
         nb_q     <= '0;
         we_q     <= 1'b0;
         wv_q     <= '0;
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         err_q    <= 1'b0;
         if_rd_q  <= '0;
         d_rd_q   <= '0;
         starve_q <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         start_q  <= start_d;
         addr_q   <= addr_d;
         nb_q     <= nb_d;
         we_q     <= we_d;
         wv_q     <= wv_d;
         if_ack_q <= if_ack_d;
         d_ack_q  <= d_ack_d;
         err_q    <= err_d;
         if_rd_q  <= if_rd_d;
         d_rd_q   <= d_rd_d;
         starve_q <= starve_d;
         timer_q  <= timer_d;
      end
   end

   assign if_ack             = if_ack_q;
   assign if_rdata           = if_rd_q;
   assign d_ack              = d_ack_q;
   assign d_rdata            = d_rd_q;
   assign err                = err_q;
   assign bus_start_request  = start_q;
   assign bus_target_address = addr_q;
   assign bus_num_bytes      = nb_q;
   assign bus_is_write       = we_q;
   assign bus_write_value    = wv_q;

endmodule
